resp_checker: RTL and testbench

- Synthesizable response checker. It is the observing end of the a/b/c stimulus pattern used across the Day_4 blocking/non-blocking experiments.
- Samples stimulus a, b, c and DUT output d on a strobe, then compares d against the intended function d = (a | b) & c.
- Counts mismatches and reports pass/fail after a programmed number of samples.
- Sits beside the DUT in gate-level (netlist) runs so that simulation mismatches are flagged in hardware rather than by eye in the VCD.

---
 rtl/resp_checker_pkg.sv | 15 +
 rtl/resp_checker_misr.sv | 33 +++
 rtl/resp_checker.sv | 127 ++++++++++++
 tb/tb_resp_checker.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/resp_checker_pkg.sv
// Shared types and constants for the resp_checker response checker:
// state encoding, MISR polynomial/seed and the intended DUT function.
package resp_checker_pkg;

    typedef enum logic [1:0] {IDLE, ARM, CHECK, DONE} state_t;

    // x^16 + x^12 + x^5 + 1, feedback taps on bits 12, 5 and 0
    localparam logic [15:0] MISR_POLY = 16'h1021;
    localparam logic [15:0] MISR_SEED = 16'hFFFF;

    function automatic logic exp_fn(input logic a, input logic b, input logic c);
        return (a | b) & c;
    endfunction

endpackage

// File: rtl/resp_checker_misr.sv
// 16-bit multiple-input signature register; seeded on load, folds din into
// the low nibble on every enabled cycle.
module resp_checker_misr
    import resp_checker_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic        en,
    input  logic [3:0]  din,
    output logic [15:0] sig
);

    logic [15:0] sig_next;

    always_comb begin
        sig_next = {sig[14:0], 1'b0} ^ {12'h000, din};
        if (sig[15]) begin
            sig_next = sig_next ^ MISR_POLY;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sig <= '0;
        end else if (load) begin
            sig <= MISR_SEED;
        end else if (en) begin
            sig <= sig_next;
        end
    end

endmodule

// File: rtl/resp_checker.sv
// Response checker comparing d against (a|b)&c, LAT strobes late, over N_SAMPLES compares.
// Define RESP_CHECKER_SIGNATURE_EN to build the MISR signature; otherwise signature is 0.
module resp_checker
    import resp_checker_pkg::*;
#(
    parameter int N_SAMPLES = 300,
    parameter int CNT_W     = 16,
    parameter int LAT       = 0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             sample_en,
    input  logic             a,
    input  logic             b,
    input  logic             c,
    input  logic             d,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic             err_pulse,
    output logic [CNT_W-1:0] err_cnt,
    output logic [CNT_W-1:0] first_err_idx,
    output logic [15:0]      signature
);

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_SAMPLES - 1);
    localparam logic [CNT_W-1:0] ALL_ONES = '1;
    localparam logic [2:0]       LAT_CNT  = 3'(LAT);
    localparam int               PW       = (LAT == 0) ? 1 : LAT;

    state_t           state;
    logic [CNT_W-1:0] sample_cnt;
    logic [2:0]       fill_cnt;
    logic [PW-1:0]    exp_pipe;
    logic             exp_now;
    logic             exp_cmp;
    logic             mismatch;

    // The oldest pipeline bit holds the expectation pushed LAT strobes ago
    assign exp_now  = exp_fn(a, b, c);
    assign exp_cmp  = (LAT == 0) ? exp_now : exp_pipe[PW-1];
    assign mismatch = (d != exp_cmp);

    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            busy          <= 1'b0;
            done          <= 1'b0;
            pass          <= 1'b0;
            err_pulse     <= 1'b0;
            err_cnt       <= '0;
            first_err_idx <= ALL_ONES;
            sample_cnt    <= '0;
            fill_cnt      <= '0;
            exp_pipe      <= '0;
        end else begin
            err_pulse <= 1'b0;
            if (sample_en && (state == ARM || state == CHECK)) begin
                exp_pipe <= (exp_pipe << 1) | PW'(exp_now);
            end
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        state         <= (LAT > 0) ? ARM : CHECK;
                        busy          <= 1'b1;
                        done          <= 1'b0;
                        pass          <= 1'b0;
                        err_cnt       <= '0;
                        first_err_idx <= ALL_ONES;
                        sample_cnt    <= '0;
                        fill_cnt      <= '0;
                    end
                end
                ARM: begin
                    if (sample_en) begin
                        fill_cnt <= fill_cnt + 3'd1;
                        if (fill_cnt == LAT_CNT - 3'd1) begin
                            state <= CHECK;
                        end
                    end
                end
                CHECK: begin
                    if (sample_en) begin
                        err_pulse <= mismatch;
                        if (mismatch && err_cnt != ALL_ONES) begin
                            err_cnt <= err_cnt + 1'b1;
                        end
                        if (mismatch && first_err_idx == ALL_ONES) begin
                            first_err_idx <= sample_cnt;
                        end
                        // Final compare: the verdict must include this strobe's result
                        if (sample_cnt == LAST_IDX) begin
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            pass  <= (err_cnt == '0) && !mismatch;
                        end else begin
                            sample_cnt <= sample_cnt + 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef RESP_CHECKER_SIGNATURE_EN
    logic run_start;
    logic strobe_chk;

    assign run_start  = start && (state == IDLE || state == DONE);
    assign strobe_chk = sample_en && (state == CHECK);

    resp_checker_misr u_misr (
        .clk   (clk),
        .reset (reset),
        .load  (run_start),
        .en    (strobe_chk),
        .din   ({a, b, c, d}),
        .sig   (signature)
    );
`else
    assign signature = 16'h0000;
`endif

endmodule

// File: tb/tb_resp_checker.sv
// Directed self-checking bench for resp_checker: a LAT=0 and a LAT=2 instance
// share the stimulus; each run drives one of them against a modelled DUT output.
module tb_resp_checker;

    localparam int N = 300;

    logic        clk = 1'b0;
    logic        reset, start0, start2, sample_en, a, b, c, d0, d2;
    logic        busy0, done0, pass0, err_pulse0;
    logic        busy2, done2, pass2, err_pulse2;
    logic [15:0] err_cnt0, first_err_idx0, signature0;
    logic [15:0] err_cnt2, first_err_idx2, signature2;
    logic        sel;

    int vectors     = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    resp_checker #(.N_SAMPLES(N), .CNT_W(16), .LAT(0)) dut_l0 (
        .clk(clk), .reset(reset), .start(start0), .sample_en(sample_en),
        .a(a), .b(b), .c(c), .d(d0),
        .busy(busy0), .done(done0), .pass(pass0), .err_pulse(err_pulse0),
        .err_cnt(err_cnt0), .first_err_idx(first_err_idx0), .signature(signature0)
    );

    resp_checker #(.N_SAMPLES(N), .CNT_W(16), .LAT(2)) dut_l2 (
        .clk(clk), .reset(reset), .start(start2), .sample_en(sample_en),
        .a(a), .b(b), .c(c), .d(d2),
        .busy(busy2), .done(done2), .pass(pass2), .err_pulse(err_pulse2),
        .err_cnt(err_cnt2), .first_err_idx(first_err_idx2), .signature(signature2)
    );

    logic        busy_s, done_s, pass_s, pulse_s;
    logic [15:0] cnt_s, first_s, sig_s;
    assign busy_s  = sel ? busy2 : busy0;
    assign done_s  = sel ? done2 : done0;
    assign pass_s  = sel ? pass2 : pass0;
    assign pulse_s = sel ? err_pulse2 : err_pulse0;
    assign cnt_s   = sel ? err_cnt2 : err_cnt0;
    assign first_s = sel ? first_err_idx2 : first_err_idx0;
    assign sig_s   = sel ? signature2 : signature0;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, want);
        end
    endtask

`ifdef RESP_CHECKER_SIGNATURE_EN
    // Reference MISR written as a rotate plus explicit taps at bits 5 and 12
    function automatic logic [15:0] misrRef(input logic [15:0] s, input logic [3:0] din);
        logic [15:0] n;
        n[0] = s[15];
        for (int i = 1; i < 16; i++) begin
            n[i] = s[i-1];
        end
        n[5]   = n[5] ^ s[15];
        n[12]  = n[12] ^ s[15];
        n[3:0] = n[3:0] ^ din;
        return n;
    endfunction
`endif

    task automatic checkReset(input string tag);
        checkOutput({tag, "/busy"}, 32'(busy_s), 32'd0);
        checkOutput({tag, "/done"}, 32'(done_s), 32'd0);
        checkOutput({tag, "/pass"}, 32'(pass_s), 32'd0);
        checkOutput({tag, "/err_pulse"}, 32'(pulse_s), 32'd0);
        checkOutput({tag, "/err_cnt"}, 32'(cnt_s), 32'd0);
        checkOutput({tag, "/first_err_idx"}, 32'(first_s), 32'hFFFF);
        checkOutput({tag, "/signature"}, 32'(sig_s), 32'd0);
    endtask

    task automatic applyStimulus(input int s, input logic dv, input bit useL2);
        a  = 1'(s % 2);
        b  = 1'((s / 5) % 2);
        c  = 1'((s / 10) % 2);
        d0 = useL2 ? 1'b0 : dv;
        d2 = useL2 ? dv : 1'b0;
        sample_en = 1'b1;
    endtask

    // mode 0: d is the expectation delayed dly strobes; 1: d uses previous a|b;
    // 2: correct d inverted at compares 7 and 20
    task automatic runCase(input string name, input bit useL2, input int mode, input int dly,
                           input int abortAt, input int midStartAt);
        int          lat    = useL2 ? 2 : 0;
        int          total  = N + lat;
        logic        hist[0:511];
        logic        prevAb = 1'b0;
        int          expErr = 0;
        int          expFirst = 'hFFFF;
        int          gotPulses = 0;
        int          pulseBad = 0;
        int          busyBad = 0;
        int          doneBad = 0;
        logic [15:0] refSig = 16'hFFFF;
        logic        av, bv, cv, dv, want, mm;
        bit          isCmp;

        sel = useL2;
        @(negedge clk);
        if (useL2) start2 = 1'b1; else start0 = 1'b1;
        @(negedge clk);
        start0 = 1'b0;
        start2 = 1'b0;
        checkOutput({name, "/busy_after_start"}, 32'(busy_s), 32'd1);

        for (int s = 0; s < total; s++) begin
            av = 1'(s % 2);
            bv = 1'((s / 5) % 2);
            cv = 1'((s / 10) % 2);
            hist[s] = (av | bv) & cv;
            case (mode)
                1:       begin dv = prevAb & cv; prevAb = av | bv; end
                2:       dv = hist[s] ^ ((s == 7) || (s == 20));
                default: dv = (s >= dly) ? hist[s - dly] : 1'b0;
            endcase
            isCmp = (s >= lat);
            mm    = 1'b0;
            if (isCmp) begin
                want = hist[s - lat];
                mm   = (dv != want);
                if (mm) begin
                    expErr++;
                    if (expFirst == 'hFFFF) expFirst = s - lat;
                end
`ifdef RESP_CHECKER_SIGNATURE_EN
                refSig = misrRef(refSig, {av, bv, cv, dv});
`endif
            end

            @(negedge clk);
            start0 = 1'b0;
            start2 = 1'b0;
            applyStimulus(s, dv, useL2);
            @(posedge clk);
            #1;
            if (mode == 2) begin
                checkOutput($sformatf("%s/err_pulse@%0d", name, s), 32'(pulse_s), 32'(mm));
            end else if (pulse_s !== mm) begin
                pulseBad++;
            end
            if (pulse_s === 1'b1) gotPulses++;
            if (busy_s !== (s < total - 1)) busyBad++;
            if (done_s !== (s == total - 1)) doneBad++;

            @(negedge clk);
            sample_en = 1'b0;
            if (isCmp && (s - lat) == abortAt) begin
                reset = 1'b1;
                @(posedge clk);
                #1;
                checkReset({name, "/abort"});
                @(negedge clk);
                reset = 1'b0;
                return;
            end
            if (isCmp && (s - lat) == midStartAt) begin
                if (useL2) start2 = 1'b1; else start0 = 1'b1;
            end
            @(posedge clk);
            #1;
            if (pulse_s !== 1'b0) pulseBad++;
        end

        checkOutput({name, "/done"}, 32'(done_s), 32'd1);
        checkOutput({name, "/pass"}, 32'(pass_s), 32'(expErr == 0));
        checkOutput({name, "/err_cnt"}, 32'(cnt_s), 32'(expErr));
        checkOutput({name, "/first_err_idx"}, 32'(first_s), 32'(expFirst));
        checkOutput({name, "/pulse_count"}, 32'(gotPulses), 32'(expErr));
        checkOutput({name, "/pulse_timing_errs"}, 32'(pulseBad), 32'd0);
        checkOutput({name, "/busy_errs"}, 32'(busyBad), 32'd0);
        checkOutput({name, "/done_timing_errs"}, 32'(doneBad), 32'd0);
`ifdef RESP_CHECKER_SIGNATURE_EN
        checkOutput({name, "/signature"}, 32'(sig_s), 32'(refSig));
`else
        checkOutput({name, "/signature"}, 32'(sig_s), 32'd0);
`endif
        @(negedge clk);
        checkOutput({name, "/done_held"}, 32'(done_s), 32'd1);
    endtask

    initial begin
        reset = 1'b1; start0 = 1'b0; start2 = 1'b0; sample_en = 1'b0;
        a = 1'b0; b = 1'b0; c = 1'b0; d0 = 1'b0; d2 = 1'b0; sel = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        sel = 1'b0;
        #1 checkReset("reset_l0");
        sel = 1'b1;
        #1 checkReset("reset_l2");
        @(negedge clk);
        reset = 1'b0;

        runCase("correct_l0", 1'b0, 0, 0, -1, -1);
        runCase("blocking_l0", 1'b0, 1, 0, -1, -1);
        runCase("inject_l0", 1'b0, 2, 0, -1, -1);
        runCase("lat2_ok", 1'b1, 0, 2, -1, -1);
        runCase("lat2_dly3", 1'b1, 0, 3, -1, -1);
        runCase("abort_l0", 1'b0, 2, 0, 150, -1);
        runCase("restart_l0", 1'b0, 0, 0, -1, 100);
        runCase("repeat_l0", 1'b0, 0, 0, -1, -1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
